// File: rtl/rob_scheduler_pkg.sv
// Shared types for the writeback/commit stage: payload type, index-width
// derivation and the packed writeback request record.
package rob_scheduler_pkg;

  typedef logic [31:0] t_msg;

  localparam int P_DEPTH_DFLT  = 4;
  localparam int P_NUM_WB_DFLT = 2;

  // Index width for a ROB of the given depth (depth is a power of two, >= 2).
  function automatic int addr_bits(input int depth);
    return $clog2(depth);
  endfunction

  localparam int P_ADDR_BITS_DFLT = addr_bits(P_DEPTH_DFLT);

  // One writeback request as seen by the ROB insert port, at default depth.
  typedef struct packed {
    t_msg                          msg;
    logic [P_ADDR_BITS_DFLT-1:0]   idx;
  } wb_req_t;

endpackage

// File: rtl/rob_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the priority
// pointer, scanning upward with wrap; pointer moves past each winner.
module rob_rr_arbiter #(
  parameter int p_num_wb = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [p_num_wb-1:0] req,
  output logic [p_num_wb-1:0] gnt
);

  localparam int PW = (p_num_wb > 1) ? $clog2(p_num_wb) : 1;
  localparam logic [PW:0] NUM = (PW+1)'(p_num_wb);

  logic [PW-1:0] prio_q, prio_d;
  logic [PW:0]   slot;
  logic          found;

  // Scan requesters starting at prio, wrapping, and pick the first one set.
  always_comb begin
    gnt    = '0;
    prio_d = prio_q;
    found  = 1'b0;
    slot   = '0;
    for (int k = 0; k < p_num_wb; k++) begin
      slot = {1'b0, prio_q} + (PW+1)'(k);
      if (slot >= NUM) slot = slot - NUM;
      if (!found && req[slot[PW-1:0]]) begin
        gnt[slot[PW-1:0]] = 1'b1;
        found             = 1'b1;
        prio_d            = ((slot + 1'b1) == NUM) ? '0 : PW'(slot + 1'b1);
      end
    end
  end

  // Priority pointer register; holds when nothing is requested.
  always_ff @(posedge clk) begin
    if (rst) prio_q <= '0;
    else     prio_q <= prio_d;
  end

endmodule

// File: rtl/rob_scheduler.sv
// ROB scheduler: in-order index allocation with occupancy tracking, and a
// round-robin writeback arbiter feeding a registered ROB insert stage.
module rob_scheduler
  import rob_scheduler_pkg::*;
#(
  parameter  int p_depth     = 4,
  parameter  int p_num_wb    = 2,
  localparam int p_addr_bits = addr_bits(p_depth)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  alloc_en,
  output logic                                  alloc_rdy,
  output logic [p_addr_bits-1:0]                alloc_idx,
  input  logic [p_num_wb-1:0]                   wb_val,
  output logic [p_num_wb-1:0]                   wb_rdy,
  input  logic [p_num_wb-1:0][p_addr_bits-1:0]  wb_idx,
  input  t_msg [p_num_wb-1:0]                   wb_msg,
  output logic                                  ins_en,
  output logic [p_addr_bits-1:0]                ins_idx,
  output t_msg                                  ins_msg,
  input  logic                                  commit_en,
  output logic [p_addr_bits:0]                  count
);

  localparam logic [p_addr_bits:0] FULL = (p_addr_bits+1)'(p_depth);

  logic [p_addr_bits-1:0] tail_q, tail_d;
  logic [p_addr_bits:0]   count_q, count_d;
  logic                   ins_en_q, ins_en_d;
  logic [p_addr_bits-1:0] ins_idx_q, ins_idx_d;
  t_msg                   ins_msg_q, ins_msg_d;
  logic [p_num_wb-1:0]    gnt;
  logic                   alloc_ok, commit_ok;
  logic [p_addr_bits-1:0] head, wb_off;
  logic                   wb_legal;

  rob_rr_arbiter #(.p_num_wb(p_num_wb)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (wb_val),
    .gnt (gnt)
  );

  // alloc_rdy looks only at registered count: a same-cycle commit does not
  // open a slot until the following cycle.
  assign alloc_rdy = (count_q != FULL);
  assign alloc_idx = tail_q;
  assign wb_rdy    = gnt;
  assign ins_en    = ins_en_q;
  assign ins_idx   = ins_idx_q;
  assign ins_msg   = ins_msg_q;
  assign count     = count_q;

  // Tail/occupancy update; illegal alloc (full) and commit (empty) are dropped.
  always_comb begin
    alloc_ok  = alloc_en && alloc_rdy;
    commit_ok = commit_en && (count_q != '0);
    tail_d    = alloc_ok ? tail_q + 1'b1 : tail_q;
    count_d   = count_q;
    if (alloc_ok && !commit_ok)      count_d = count_q + 1'b1;
    else if (!alloc_ok && commit_ok) count_d = count_q - 1'b1;
  end

  // Insert-stage mux: capture the granted request, otherwise hold payload.
  always_comb begin
    ins_en_d  = |gnt;
    ins_idx_d = ins_idx_q;
    ins_msg_d = ins_msg_q;
    for (int i = 0; i < p_num_wb; i++) begin
      if (gnt[i]) begin
        ins_idx_d = wb_idx[i];
        ins_msg_d = wb_msg[i];
      end
    end
    // Entry is allocated when its distance from the head is below count.
    head     = tail_q - count_q[p_addr_bits-1:0];
    wb_off   = ins_idx_d - head;
    wb_legal = !(|gnt) || ({1'b0, wb_off} < count_q);
  end

  // State registers: allocation pointer, occupancy and insert stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      tail_q    <= '0;
      count_q   <= '0;
      ins_en_q  <= 1'b0;
      ins_idx_q <= '0;
      ins_msg_q <= '0;
    end else begin
      tail_q    <= tail_d;
      count_q   <= count_d;
      ins_en_q  <= ins_en_d;
      ins_idx_q <= ins_idx_d;
      ins_msg_q <= ins_msg_d;
    end
  end

  a_commit_empty: assert property (@(posedge clk) disable iff (rst)
    commit_en |-> (count_q != '0))
    else $warning("commit_en with empty ROB ignored");

  a_alloc_full: assert property (@(posedge clk) disable iff (rst)
    alloc_en |-> alloc_rdy)
    else $warning("alloc_en with full ROB ignored");

  a_wb_unallocated: assert property (@(posedge clk) disable iff (rst)
    wb_legal)
    else $warning("writeback to unallocated ROB index");

endmodule

// File: tb/tb_rob_scheduler.sv
// Bench for rob_scheduler: directed scenarios plus randomized traffic checked
// against an occupancy/round-robin reference model.
module tb_rob_scheduler;
  import rob_scheduler_pkg::*;

  localparam int D  = 4;
  localparam int N  = 2;
  localparam int AB = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  alloc_en;
  logic                  alloc_rdy;
  logic [AB-1:0]         alloc_idx;
  logic [N-1:0]          wb_val;
  logic [N-1:0]          wb_rdy;
  logic [N-1:0][AB-1:0]  wb_idx;
  t_msg [N-1:0]          wb_msg;
  logic                  ins_en;
  logic [AB-1:0]         ins_idx;
  t_msg                  ins_msg;
  logic                  commit_en;
  logic [AB:0]           count;

  int vecs = 0;
  int errs = 0;

  // Reference model state
  int            m_count, m_tail, m_prio;
  logic          m_ins_en;
  logic [AB-1:0] m_ins_idx;
  t_msg          m_ins_msg;

  always #5 clk = ~clk;

  rob_scheduler #(.p_depth(D), .p_num_wb(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .alloc_en  (alloc_en),
    .alloc_rdy (alloc_rdy),
    .alloc_idx (alloc_idx),
    .wb_val    (wb_val),
    .wb_rdy    (wb_rdy),
    .wb_idx    (wb_idx),
    .wb_msg    (wb_msg),
    .ins_en    (ins_en),
    .ins_idx   (ins_idx),
    .ins_msg   (ins_msg),
    .commit_en (commit_en),
    .count     (count)
  );

  // First requester at or after p, wrapping; -1 when nobody asks.
  function automatic int ref_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (((v >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] grant_vec(input int g);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (i == g) r[i] = 1'b1;
    return r;
  endfunction

  // Advance the model by the current inputs, then cross the clock edge.
  task automatic tick();
    int g;
    bit a_ok, c_ok;
    g = ref_grant(wb_val, m_prio);
    if (rst) begin
      m_count = 0; m_tail = 0; m_prio = 0;
      m_ins_en = 1'b0; m_ins_idx = '0; m_ins_msg = '0;
    end else begin
      a_ok = alloc_en && (m_count < D);
      c_ok = commit_en && (m_count > 0);
      if (a_ok) m_tail = (m_tail + 1) % D;
      m_count = m_count + int'(a_ok) - int'(c_ok);
      m_ins_en = (g >= 0);
      if (g >= 0) begin
        m_prio = (g + 1) % N;
        for (int i = 0; i < N; i++)
          if (i == g) begin m_ins_idx = wb_idx[i]; m_ins_msg = wb_msg[i]; end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic a, input logic c, input logic [N-1:0] v);
    @(negedge clk);
    alloc_en = a; commit_en = c; wb_val = v;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; alloc_en = 1'b0; commit_en = 1'b0; wb_val = '0;
    wb_idx = '0; wb_msg = '0;
    tick(); tick();
    @(negedge clk); rst = 1'b0; #1;
    vecs++; if (alloc_rdy !== 1'b1) begin errs++; $display("FAIL reset_alloc_rdy: got %b want 1", alloc_rdy); end
    vecs++; if (alloc_idx !== 2'd0) begin errs++; $display("FAIL reset_alloc_idx: got %0d want 0", alloc_idx); end
    vecs++; if (wb_rdy !== 2'b00) begin errs++; $display("FAIL reset_wb_rdy: got %b want 00", wb_rdy); end
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", count); end
    vecs++; if (ins_en !== 1'b0) begin errs++; $display("FAIL reset_ins_en: got %b want 0", ins_en); end
    vecs++; if (ins_idx !== 2'd0) begin errs++; $display("FAIL reset_ins_idx: got %0d want 0", ins_idx); end
    vecs++; if (ins_msg !== 32'h0) begin errs++; $display("FAIL reset_ins_msg: got %h want 0", ins_msg); end
  endtask

  task automatic test_alloc_fill();
    for (int i = 0; i < D; i++) begin
      set_in(1'b1, 1'b0, '0);
      vecs++; if (alloc_idx !== AB'(i)) begin errs++; $display("FAIL fill_idx[%0d]: got %0d want %0d", i, alloc_idx, i); end
      vecs++; if (alloc_rdy !== 1'b1) begin errs++; $display("FAIL fill_rdy[%0d]: got %b want 1", i, alloc_rdy); end
      tick();
    end
    vecs++; if (count !== 3'd4) begin errs++; $display("FAIL fill_count: got %0d want 4", count); end
    vecs++; if (alloc_rdy !== 1'b0) begin errs++; $display("FAIL fill_full_rdy: got %b want 0", alloc_rdy); end
    set_in(1'b1, 1'b0, '0);
    tick();
    vecs++; if (count !== 3'd4) begin errs++; $display("FAIL overflow_count: got %0d want 4", count); end
    vecs++; if (alloc_idx !== 2'd0) begin errs++; $display("FAIL overflow_tail: got %0d want 0", alloc_idx); end
  endtask

  task automatic test_commit_alloc_full();
    set_in(1'b1, 1'b1, '0);
    vecs++; if (alloc_rdy !== 1'b0) begin errs++; $display("FAIL full_commit_rdy: got %b want 0", alloc_rdy); end
    tick();
    vecs++; if (count !== 3'd3) begin errs++; $display("FAIL full_commit_count: got %0d want 3", count); end
    vecs++; if (alloc_rdy !== 1'b1) begin errs++; $display("FAIL freed_rdy: got %b want 1", alloc_rdy); end
    vecs++; if (alloc_idx !== 2'd0) begin errs++; $display("FAIL wrap_idx: got %0d want 0", alloc_idx); end
    set_in(1'b1, 1'b0, '0);
    tick();
    vecs++; if (count !== 3'd4) begin errs++; $display("FAIL refill_count: got %0d want 4", count); end
  endtask

  task automatic test_rr_both();
    wb_req_t       tab [N];
    logic [N-1:0]  gexp [4];
    tab[0].msg = 32'hdeadbeef; tab[0].idx = 2'd0;
    tab[1].msg = 32'h12345678; tab[1].idx = 2'd1;
    gexp[0] = 2'b01; gexp[1] = 2'b10; gexp[2] = 2'b01; gexp[3] = 2'b10;
    for (int i = 0; i < N; i++) begin wb_idx[i] = tab[i].idx; wb_msg[i] = tab[i].msg; end
    for (int c = 0; c < 4; c++) begin
      set_in(1'b0, 1'b0, 2'b11);
      vecs++; if (wb_rdy !== gexp[c]) begin errs++; $display("FAIL rr_grant[%0d]: got %b want %b", c, wb_rdy, gexp[c]); end
      tick();
      vecs++; if (ins_en !== 1'b1) begin errs++; $display("FAIL rr_ins_en[%0d]: got %b want 1", c, ins_en); end
      vecs++; if (ins_idx !== tab[c % 2].idx) begin errs++; $display("FAIL rr_ins_idx[%0d]: got %0d want %0d", c, ins_idx, tab[c % 2].idx); end
      vecs++; if (ins_msg !== tab[c % 2].msg) begin errs++; $display("FAIL rr_ins_msg[%0d]: got %h want %h", c, ins_msg, tab[c % 2].msg); end
    end
    set_in(1'b0, 1'b0, 2'b00);
    vecs++; if (wb_rdy !== 2'b00) begin errs++; $display("FAIL idle_wb_rdy: got %b want 00", wb_rdy); end
    tick();
    vecs++; if (ins_en !== 1'b0) begin errs++; $display("FAIL idle_ins_en: got %b want 0", ins_en); end
    vecs++; if (ins_idx !== 2'd1 || ins_msg !== 32'h12345678) begin errs++; $display("FAIL idle_hold: got %0d/%h want 1/12345678", ins_idx, ins_msg); end
  endtask

  task automatic test_single_req1();
    wb_idx[1] = 2'd3; wb_msg[1] = 32'hFFFFFFFF;
    set_in(1'b0, 1'b0, 2'b10);
    vecs++; if (wb_rdy !== 2'b10) begin errs++; $display("FAIL req1_grant: got %b want 10", wb_rdy); end
    tick();
    vecs++; if (ins_en !== 1'b1) begin errs++; $display("FAIL req1_ins_en: got %b want 1", ins_en); end
    vecs++; if (ins_idx !== 2'd3) begin errs++; $display("FAIL req1_ins_idx: got %0d want 3", ins_idx); end
    vecs++; if (ins_msg !== 32'hFFFFFFFF) begin errs++; $display("FAIL req1_ins_msg: got %h want ffffffff", ins_msg); end
    set_in(1'b0, 1'b0, 2'b00);
    tick();
  endtask

  // ROB is full here, so every index is a legal writeback target.
  task automatic test_random_wb();
    int g;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      alloc_en = 1'b0; commit_en = 1'b0;
      wb_val = N'($urandom);
      for (int i = 0; i < N; i++) begin wb_idx[i] = AB'($urandom); wb_msg[i] = $urandom; end
      #1;
      g = ref_grant(wb_val, m_prio);
      vecs++; if (wb_rdy !== grant_vec(g)) begin errs++; $display("FAIL rnd_grant[%0d]: got %b want %b", c, wb_rdy, grant_vec(g)); end
      tick();
      vecs++; if (ins_en !== m_ins_en) begin errs++; $display("FAIL rnd_ins_en[%0d]: got %b want %b", c, ins_en, m_ins_en); end
      vecs++; if (ins_idx !== m_ins_idx) begin errs++; $display("FAIL rnd_ins_idx[%0d]: got %0d want %0d", c, ins_idx, m_ins_idx); end
      vecs++; if (ins_msg !== m_ins_msg) begin errs++; $display("FAIL rnd_ins_msg[%0d]: got %h want %h", c, ins_msg, m_ins_msg); end
    end
  endtask

  task automatic test_random_alloc();
    logic a, c;
    for (int k = 0; k < 150; k++) begin
      a = (m_count < D) ? 1'($urandom) : 1'b0;
      c = (m_count > 0) ? 1'($urandom) : 1'b0;
      set_in(a, c, '0);
      vecs++; if (alloc_rdy !== (m_count != D)) begin errs++; $display("FAIL rnd_rdy[%0d]: got %b want %b", k, alloc_rdy, (m_count != D)); end
      vecs++; if (alloc_idx !== AB'(m_tail)) begin errs++; $display("FAIL rnd_tail[%0d]: got %0d want %0d", k, alloc_idx, m_tail); end
      tick();
      vecs++; if (count !== (AB+1)'(m_count)) begin errs++; $display("FAIL rnd_count[%0d]: got %0d want %0d", k, count, m_count); end
    end
  endtask

  task automatic test_rob_inorder();
    logic [AB-1:0] ord [4];
    bit            rob_v [D];
    t_msg          rob_d [D];
    int            head;
    ord[0] = 2'd3; ord[1] = 2'd1; ord[2] = 2'd2; ord[3] = 2'd0;
    for (int i = 0; i < D; i++) begin rob_v[i] = 1'b0; rob_d[i] = '0; end
    @(negedge clk); rst = 1'b1; alloc_en = 1'b0; commit_en = 1'b0; wb_val = '0; #1;
    tick();
    @(negedge clk); rst = 1'b0; #1;
    for (int i = 0; i < D; i++) begin
      set_in(1'b1, 1'b0, '0);
      vecs++; if (alloc_idx !== AB'(i)) begin errs++; $display("FAIL rob_alloc[%0d]: got %0d want %0d", i, alloc_idx, i); end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      alloc_en = 1'b0; wb_val = 2'b01; wb_idx[0] = ord[k]; wb_msg[0] = 32'hA0 + 32'(ord[k]);
      #1;
      tick();
      if (ins_en === 1'b1) begin rob_v[ins_idx] = 1'b1; rob_d[ins_idx] = ins_msg; end
    end
    set_in(1'b0, 1'b0, '0);
    tick();
    head = 0;
    for (int b = 0; b < 8 && head < D; b++) begin
      if (rob_v[head]) begin
        vecs++; if (rob_d[head] !== 32'hA0 + 32'(head)) begin errs++; $display("FAIL rob_deq[%0d]: got %h want %h", head, rob_d[head], 32'hA0 + 32'(head)); end
        rob_v[head] = 1'b0;
        set_in(1'b0, 1'b1, '0);
        tick();
        head++;
        vecs++; if (count !== (AB+1)'(D - head)) begin errs++; $display("FAIL rob_count[%0d]: got %0d want %0d", head, count, D - head); end
      end else begin
        set_in(1'b0, 1'b0, '0);
        tick();
      end
    end
    vecs++; if (head != D) begin errs++; $display("FAIL rob_drain: got %0d dequeued want %0d", head, D); end
    set_in(1'b0, 1'b0, '0);
  endtask

  task automatic test_reset_mid();
    set_in(1'b1, 1'b0, '0);
    tick();
    @(negedge clk);
    alloc_en = 1'b0; wb_val = 2'b01; wb_idx[0] = 2'd0; wb_msg[0] = 32'h55;
    #1;
    vecs++; if (wb_rdy !== 2'b01) begin errs++; $display("FAIL mid_grant: got %b want 01", wb_rdy); end
    tick();
    vecs++; if (ins_en !== 1'b1) begin errs++; $display("FAIL mid_ins_en: got %b want 1", ins_en); end
    @(negedge clk); rst = 1'b1; #1;
    tick();
    vecs++; if (ins_en !== 1'b0) begin errs++; $display("FAIL mid_rst_ins_en: got %b want 0", ins_en); end
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL mid_rst_count: got %0d want 0", count); end
    vecs++; if (alloc_idx !== 2'd0) begin errs++; $display("FAIL mid_rst_idx: got %0d want 0", alloc_idx); end
    @(negedge clk); rst = 1'b0; wb_val = '0; #1;
    tick();
    vecs++; if (ins_en !== 1'b0) begin errs++; $display("FAIL post_rst_ins_en: got %b want 0", ins_en); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alloc_fill();
    test_commit_alloc_full();
    test_rr_both();
    test_single_req1();
    test_random_wb();
    test_random_alloc();
    test_rob_inorder();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
